// File: rtl/easyaxi_txn_sched.sv
// Burst scheduler for the EasyAXI master core: issues NUM_TXN write bursts, drains their
// completions, then issues and drains the matching read bursts, bounded by MAX_OUTST in flight.
module easyaxi_txn_sched #(
  parameter int                ADDR_W    = 32,
  parameter int                LEN_W     = 8,
  parameter int                NUM_TXN   = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] ADDR_STEP = 32'h0000_0100,
  parameter logic [LEN_W-1:0]  BURST_LEN = 8'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              done,
  output logic              error,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cpl_valid,
  input  logic              cpl_write,
  input  logic [1:0]        cpl_resp
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ISSUE, S_WR_DRAIN, S_RD_ISSUE, S_RD_DRAIN, S_DONE
  } state_t;

  localparam logic [7:0] NUM_C = 8'(NUM_TXN);
  localparam logic [3:0] MAX_C = 4'(MAX_OUTST);

  state_t            state_q, state_d;
  logic [7:0]        issued_q, issued_d;
  logic [7:0]        completed_q, completed_d;
  logic [3:0]        outst_q, outst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;

  logic hs, phase_wr, phase_rd, cpl_ok, cpl_spur, start;

  always_comb begin
    hs       = cmd_valid_q & cmd_ready;
    phase_wr = (state_q == S_WR_ISSUE) || (state_q == S_WR_DRAIN);
    phase_rd = (state_q == S_RD_ISSUE) || (state_q == S_RD_DRAIN);
    cpl_ok   = cpl_valid && (outst_q != 4'd0) &&
               ((phase_wr && cpl_write) || (phase_rd && !cpl_write));
    cpl_spur = cpl_valid && !cpl_ok;
    start    = (state_q == S_IDLE) && enable;

    state_d     = state_q;
    issued_d    = issued_q + {7'd0, hs};
    completed_d = completed_q + {7'd0, cpl_ok};
    outst_d     = outst_q + {3'd0, hs} - {3'd0, cpl_ok};
    cmd_addr_d  = hs ? (cmd_addr_q + ADDR_STEP) : cmd_addr_q;
    cmd_write_d = cmd_write_q;
    cmd_len_d   = cmd_len_q;
    // A spurious completion arriving on the start cycle still flags the new run.
    error_d     = (start ? 1'b0 : error_q) | cpl_spur | (cpl_ok && (cpl_resp != 2'b00));

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_WR_ISSUE;
          issued_d    = 8'd0;
          completed_d = 8'd0;
          outst_d     = 4'd0;
          cmd_addr_d  = BASE_ADDR;
          cmd_write_d = 1'b1;
          cmd_len_d   = BURST_LEN;
        end
      end
      S_WR_ISSUE: begin
        if (issued_d == NUM_C) state_d = S_WR_DRAIN;
      end
      S_WR_DRAIN: begin
        if (completed_q == NUM_C) begin
          state_d     = S_RD_ISSUE;
          issued_d    = 8'd0;
          completed_d = 8'd0;
          outst_d     = 4'd0;
          cmd_addr_d  = BASE_ADDR;
          cmd_write_d = 1'b0;
        end
      end
      S_RD_ISSUE: begin
        if (issued_d == NUM_C) state_d = S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        if (completed_q == NUM_C) state_d = S_DONE;
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Valid is derived from next-state registers only, so it never follows cmd_ready.
    cmd_valid_d = ((state_d == S_WR_ISSUE) || (state_d == S_RD_ISSUE)) &&
                  (issued_d < NUM_C) && (outst_d < MAX_C);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issued_q    <= 8'd0;
      completed_q <= 8'd0;
      outst_q     <= 4'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      outst_q     <= outst_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign done      = done_q;
  assign error     = error_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;

endmodule

// File: tb/tb_easyaxi_txn_sched.sv
// Directed bench for easyaxi_txn_sched: a phase/count model predicts the outputs every cycle,
// and literal expectations pin the address sequence, backpressure, limits and error handling.
`timescale 1ns/1ps
module tb_easyaxi_txn_sched;
  localparam int          NUM  = 4;
  localparam int          MAX  = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] STEP = 32'h0000_0100;
  localparam logic [7:0]  BLEN = 8'd3;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, cmd_ready = 1'b0;
  logic        cpl_valid = 1'b0, cpl_write = 1'b0;
  logic [1:0]  cpl_resp = 2'b00;
  logic        done, error, cmd_valid, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;

  easyaxi_txn_sched #(
    .ADDR_W(32), .LEN_W(8), .NUM_TXN(NUM), .MAX_OUTST(MAX),
    .BASE_ADDR(BASE), .ADDR_STEP(STEP), .BURST_LEN(BLEN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .done(done), .error(error),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cpl_valid(cpl_valid), .cpl_write(cpl_write), .cpl_resp(cpl_resp)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  typedef struct { int due; logic w; logic [1:0] resp; } cpl_t;
  cpl_t        cq[$];
  logic [31:0] hs_addr[$];
  logic        hs_wr[$];
  bit          auto_cpl = 0, chk_en = 0;
  int          bad_wr_idx = -1, wr_hs_cnt = 0, obs_out = 0, max_out = 0;

  // Abstract model: phase 0 idle, 1 writes, 2 reads, 3 done.
  int m_ph = 0, m_iss = 0, m_cpl = 0, m_out = 0;
  bit m_err = 0;

  function automatic bit m_vld();
    return (m_ph == 1 || m_ph == 2) && m_iss < NUM && m_out < MAX;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin : model
    bit good, spur, hsm, berr;
    @(posedge clk);
    hsm  = m_vld() && (cmd_ready === 1'b1);
    good = (cpl_valid === 1'b1) && (m_ph == 1 || m_ph == 2) &&
           (cpl_write === (m_ph == 1)) && m_out > 0;
    spur = (cpl_valid === 1'b1) && !good;
    berr = good && cpl_resp != 2'b00;
    if (rst) begin
      m_ph = 0; m_iss = 0; m_cpl = 0; m_out = 0; m_err = 0;
    end else begin
      m_err = ((m_ph == 0 && enable) ? 1'b0 : m_err) | spur | berr;
      if (m_ph == 0) begin
        if (enable) begin m_ph = 1; m_iss = 0; m_cpl = 0; m_out = 0; end
      end else if (m_ph == 3) begin
        if (!enable) m_ph = 0;
      end else if (m_iss == NUM && m_cpl == NUM) begin
        m_ph = m_ph + 1; m_iss = 0; m_cpl = 0; m_out = 0;
      end else begin
        m_iss = m_iss + int'(hsm);
        m_cpl = m_cpl + int'(good);
        m_out = m_out + int'(hsm) - int'(good);
      end
    end
  end

  initial forever begin : monitor
    @(negedge clk);
    if (chk_en) begin
      check("cmd_valid", cmd_valid, m_vld());
      check("done", done, m_ph == 3);
      check("error", error, m_err);
      if (m_vld()) begin
        check("cmd_write", cmd_write, m_ph == 1);
        check("cmd_addr", cmd_addr, BASE + 32'(m_iss) * STEP);
        check("cmd_len", cmd_len, BLEN);
      end
    end
    if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      hs_addr.push_back(cmd_addr);
      hs_wr.push_back(cmd_write);
      $display("cyc %0d cmd %s addr=%h len=%0d", cyc, cmd_write ? "WR" : "RD", cmd_addr, cmd_len);
      if (auto_cpl)
        cq.push_back('{cyc + 3, cmd_write,
                       (cmd_write && wr_hs_cnt == bad_wr_idx) ? 2'b10 : 2'b00});
      if (cmd_write) wr_hs_cnt++;
      obs_out++;
      if (obs_out > max_out) max_out = obs_out;
    end
    if (cpl_valid === 1'b1) begin
      $display("cyc %0d cpl %s resp=%0d", cyc, cpl_write ? "WR" : "RD", cpl_resp);
      if (obs_out > 0) obs_out--;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      cpl_valid = 1'b0; cpl_write = 1'b0; cpl_resp = 2'b00;
      for (int i = 0; i < cq.size(); i++) begin
        if (cq[i].due <= cyc) begin
          cpl_valid = 1'b1; cpl_write = cq[i].w; cpl_resp = cq[i].resp;
          cq.delete(i);
          break;
        end
      end
    end
  endtask

  task automatic push_cpl(logic w, logic [1:0] resp);
    cq.push_back('{cyc + 1, w, resp});
  endtask

  task automatic wait_done(int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin tick(); n++; end
    check("done_reached", done, 1'b1);
  endtask

  task automatic wait_hs(int cnt, int lim);
    int n = 0;
    while (hs_addr.size() < cnt && n < lim) begin tick(); n++; end
    check("hs_reached", hs_addr.size(), cnt);
  endtask

  function automatic bit has_rd();
    foreach (hs_wr[i]) if (hs_wr[i] == 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clr_logs();
    hs_addr.delete(); hs_wr.delete();
    wr_hs_cnt = 0; obs_out = 0; max_out = 0;
  endtask

  task automatic check_zero_outs(string tag);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_write"}, cmd_write, 0);
    check({tag, "_addr"}, cmd_addr, 0);
    check({tag, "_len"}, cmd_len, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr[8];
    int n;
    exp_addr = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000, 32'h100, 32'h200, 32'h300};

    // Reset
    tick(); chk_en = 1; tick();
    rst = 1'b0;
    check_zero_outs("reset");

    // Basic run with 3-cycle completion latency
    clr_logs(); auto_cpl = 1; cmd_ready = 1'b1; enable = 1'b1;
    wait_done(300);
    check("basic_hs_count", hs_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < hs_addr.size()) begin
        check("basic_addr", hs_addr[i], exp_addr[i]);
        check("basic_write", hs_wr[i], (i < 4) ? 1'b1 : 1'b0);
      end
    end
    check("basic_max_outst", max_out, 2);
    check("basic_error", error, 0);
    enable = 1'b0; tick();
    check("basic_done_drop", done, 0);

    // Backpressure on the first write
    clr_logs(); cmd_ready = 1'b0; enable = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", cmd_valid, 1);
      check("bp_addr", cmd_addr, 32'h000);
      check("bp_write", cmd_write, 1);
      tick();
    end
    cmd_ready = 1'b1; tick();
    check("bp_hs_count", hs_addr.size(), 1);
    if (hs_addr.size() > 0) check("bp_hs_addr", hs_addr[0], 32'h000);
    wait_done(300);
    enable = 1'b0; tick(2);

    // Outstanding limit with manual completions
    clr_logs(); auto_cpl = 0; enable = 1'b1;
    wait_hs(2, 20); tick(3);
    check("lim_hs_count", hs_addr.size(), 2);
    check("lim_valid_blocked", cmd_valid, 0);
    push_cpl(1'b1, 2'b00); tick();
    push_cpl(1'b1, 2'b00); tick();
    check("lim_valid_reopen", cmd_valid, 1);
    check("lim_addr_reopen", cmd_addr, 32'h200);
    tick();
    check("lim_hs3", hs_addr.size(), 3);
    check("lim_valid_after_simul", cmd_valid, 1);
    check("lim_addr_after_simul", cmd_addr, 32'h300);
    tick();
    check("lim_hs4", hs_addr.size(), 4);
    check("lim_valid_drain", cmd_valid, 0);
    auto_cpl = 1;
    push_cpl(1'b1, 2'b00); push_cpl(1'b1, 2'b00);
    wait_done(300);
    check("lim_error", error, 0);
    enable = 1'b0; tick(2);

    // Error response on third write
    clr_logs(); bad_wr_idx = 2; enable = 1'b1;
    wait_done(300);
    check("err_flag", error, 1);
    check("err_hs_count", hs_addr.size(), 8);
    if (hs_wr.size() > 4) check("err_reads_issued", hs_wr[4], 0);
    enable = 1'b0; tick();
    check("err_hold_idle", error, 1);
    bad_wr_idx = -1; enable = 1'b1; tick();
    check("err_cleared", error, 0);
    wait_done(300);
    check("err_clean_run", error, 0);
    enable = 1'b0; tick(2);

    // Spurious completions: idle, and wrong phase during write drain
    push_cpl(1'b1, 2'b00); tick(2);
    check("spur_idle", error, 1);
    clr_logs(); auto_cpl = 0; enable = 1'b1; tick();
    check("spur_start_clear", error, 0);
    wait_hs(2, 20);
    push_cpl(1'b1, 2'b00); push_cpl(1'b1, 2'b00);
    wait_hs(4, 30); tick(2);
    push_cpl(1'b0, 2'b00); tick(2);
    check("spur_phase", error, 1);
    check("spur_no_read", cmd_valid, 0);
    push_cpl(1'b1, 2'b00); tick(3);
    check("spur_still_drain", cmd_valid, 0);
    auto_cpl = 1; push_cpl(1'b1, 2'b00);
    wait_done(300);
    check("spur_hs_count", hs_addr.size(), 8);
    check("spur_err_end", error, 1);
    enable = 1'b0; tick(2);

    // Reset during read issue, then enable dropped mid-run
    clr_logs(); enable = 1'b1;
    n = 0;
    while (!has_rd() && n < 100) begin tick(); n++; end
    check("rst_read_seen", has_rd(), 1);
    rst = 1'b1; cq.delete(); tick();
    check_zero_outs("midrst");
    rst = 1'b0;
    tick(3); enable = 1'b0;
    wait_done(300);
    tick();
    check("drop_done_pulse", done, 0);
    check("drop_error", error, 0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
